axis_cmd_scheduler: RTL and testbench

// Shares one downstream 96-bit command-word serializer between two AXI4-Stream command sources.

---
 rtl/axis_cmd_scheduler.sv | 113 +++++++++++
 tb/tb_axis_cmd_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_cmd_scheduler.sv
// Round-robin scheduler sharing one command-word serializer between two
// AXI4-Stream sources, with a programmable idle gap after each word.
module axis_cmd_scheduler #(
   parameter int DATA_WIDTH = 96,
   parameter int CNTR_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [CNTR_WIDTH-1:0] cfg_data,
   input  logic [DATA_WIDTH-1:0] s_axis0_tdata,
   input  logic                  s_axis0_tvalid,
   output logic                  s_axis0_tready,
   input  logic [DATA_WIDTH-1:0] s_axis1_tdata,
   input  logic                  s_axis1_tvalid,
   output logic                  s_axis1_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tid,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  sts_busy
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      HOLD
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_last_grant;
   logic [CNTR_WIDTH-1:0]   r_cnt;
   logic [DATA_WIDTH-1:0]   r_tdata;
   logic                    r_tid;
   logic                    r_tvalid;
   logic                    w_grant0;
   logic                    w_grant1;
   logic                    w_hs;
   logic                    w_cnt_last;

   // Contention goes to the source that did not win last time.
   assign w_grant0   = s_axis0_tvalid & (~s_axis1_tvalid | r_last_grant);
   assign w_grant1   = s_axis1_tvalid & (~s_axis0_tvalid | ~r_last_grant);
   assign w_hs       = r_tvalid & m_axis_tready;
   assign w_cnt_last = (r_cnt == CNTR_WIDTH'(1));

   assign s_axis0_tready = (r_state == IDLE) & w_grant0 & ~areset;
   assign s_axis1_tready = (r_state == IDLE) & w_grant1 & ~areset;
   assign m_axis_tdata   = r_tdata;
   assign m_axis_tid     = r_tid;
   assign m_axis_tvalid  = r_tvalid;
   assign sts_busy       = (r_state != IDLE);

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_grant0 | w_grant1) w_next = SEND;
         SEND: begin
            if (w_hs) begin
               if (cfg_data == '0) w_next = IDLE;
               else                w_next = HOLD;
            end
         end
         HOLD: if (w_cnt_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (areset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Word capture, hand-off and hold-off countdown.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_tdata      <= '0;
         r_tid        <= 1'b0;
         r_tvalid     <= 1'b0;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_grant0) begin
                  r_tdata      <= s_axis0_tdata;
                  r_tid        <= 1'b0;
                  r_last_grant <= 1'b0;
                  r_tvalid     <= 1'b1;
               end else if (w_grant1) begin
                  r_tdata      <= s_axis1_tdata;
                  r_tid        <= 1'b1;
                  r_last_grant <= 1'b1;
                  r_tvalid     <= 1'b1;
               end
            end
            SEND: begin
               if (w_hs) begin
                  r_tvalid <= 1'b0;
                  r_cnt    <= cfg_data;
               end
            end
            HOLD: begin
               if (r_cnt > CNTR_WIDTH'(1)) r_cnt <= r_cnt - CNTR_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_cmd_scheduler.sv
// Directed testbench for axis_cmd_scheduler: reset, single word, round-robin,
// hold-off gap, back-pressure, mid-flight reset and cfg sampling.
module tb_axis_cmd_scheduler;

   localparam int DW = 96;
   localparam int CW = 32;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [CW-1:0] cfg_data = '0;
   logic [DW-1:0] s0_tdata = '0;
   logic          s0_tvalid = 1'b0;
   logic          s0_tready;
   logic [DW-1:0] s1_tdata = '0;
   logic          s1_tvalid = 1'b0;
   logic          s1_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tid;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [DW-1:0] D1 = 96'h0000_0000_0000_0000_0011_1234;
   localparam logic [DW-1:0] DA = 96'hAAAA_0001_AAAA_0002_AAAA_0003;
   localparam logic [DW-1:0] DB = 96'hBBBB_0004_BBBB_0005_BBBB_0006;
   localparam logic [DW-1:0] DC = 96'hCCCC_CCCC_1234_5678_9ABC_DEF0;

   always #5 aclk = ~aclk;

   axis_cmd_scheduler #(.DATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .cfg_data       (cfg_data),
      .s_axis0_tdata  (s0_tdata),
      .s_axis0_tvalid (s0_tvalid),
      .s_axis0_tready (s0_tready),
      .s_axis1_tdata  (s1_tdata),
      .s_axis1_tvalid (s1_tvalid),
      .s_axis1_tready (s1_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tid     (m_tid),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .sts_busy       (busy)
   );

   // One-cycle reset pulse; returns just after the reset edge.
   task automatic do_reset();
      @(negedge aclk);
      areset    = 1'b1;
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
      m_tready  = 1'b0;
      cfg_data  = '0;
      @(posedge aclk);
      #1 areset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge aclk);
      areset    = 1'b1;
      s0_tvalid = 1'b1;
      s1_tvalid = 1'b1;
      #1;
      n_tests++;
      if ({s1_tready, s0_tready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_tready got=%b exp=00", {s1_tready, s0_tready});
      end
      @(negedge aclk);
      #1;
      n_tests++;
      if ({m_tvalid, m_tid, busy} !== 3'b000 || m_tdata !== '0) begin
         n_fail++;
         $display("FAIL reset_state got v/id/busy=%b%b%b data=%h exp=000 data=0",
                  m_tvalid, m_tid, busy, m_tdata);
      end
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
      @(posedge aclk);
      #1 areset = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      cfg_data = 0;
      m_tready = 1'b1;
      @(negedge aclk);
      s0_tdata  = D1;
      s0_tvalid = 1'b1;
      #1;
      n_tests++;
      if ({s1_tready, s0_tready} !== 2'b01) begin
         n_fail++;
         $display("FAIL single_grant got=%b exp=01", {s1_tready, s0_tready});
      end
      @(negedge aclk);
      s0_tvalid = 1'b0;
      #1;
      n_tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== D1 || m_tid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_word got v=%b id=%b d=%h exp v=1 id=0 d=%h",
                  m_tvalid, m_tid, m_tdata, D1);
      end
      @(negedge aclk);
      #1;
      n_tests++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle got busy=%b v=%b exp 0 0", busy, m_tvalid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0]    exp_rdy;
      logic [DW-1:0] exp_d;
      logic          exp_id;
      do_reset();
      cfg_data = 0;
      m_tready = 1'b1;
      s0_tdata = DA;
      s1_tdata = DB;
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         s0_tvalid = 1'b1;
         s1_tvalid = 1'b1;
         #1;
         exp_id = ((i / 2) % 2) == 1;
         n_tests++;
         if (i % 2 == 0) begin
            exp_rdy = exp_id ? 2'b10 : 2'b01;
            if ({s1_tready, s0_tready} !== exp_rdy || m_tvalid !== 1'b0) begin
               n_fail++;
               $display("FAIL rr_grant c%0d got rdy=%b v=%b exp rdy=%b v=0",
                        i, {s1_tready, s0_tready}, m_tvalid, exp_rdy);
            end
         end else begin
            exp_d = exp_id ? DB : DA;
            if (m_tvalid !== 1'b1 || m_tdata !== exp_d || m_tid !== exp_id ||
                {s1_tready, s0_tready} !== 2'b00) begin
               n_fail++;
               $display("FAIL rr_word c%0d got v=%b id=%b d=%h exp v=1 id=%b d=%h",
                        i, m_tvalid, m_tid, m_tdata, exp_id, exp_d);
            end
         end
      end
      @(negedge aclk);
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
   endtask

   task automatic test_hold_gap();
      do_reset();
      cfg_data = 3;
      m_tready = 1'b1;
      s1_tdata = DB;
      @(negedge aclk);
      s1_tvalid = 1'b1;
      #1;
      n_tests++;
      if (s1_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_first_grant got=%b exp=1", s1_tready);
      end
      // cycle 1 is the handshake cycle H; H+1..H+3 hold, H+4 grants.
      for (int c = 1; c <= 5; c++) begin
         @(negedge aclk);
         #1;
         n_tests++;
         if (c <= 4) begin
            if (busy !== 1'b1 || s1_tready !== 1'b0) begin
               n_fail++;
               $display("FAIL hold_gap H+%0d got busy=%b rdy=%b exp 1 0",
                        c - 1, busy, s1_tready);
            end
         end else begin
            if (busy !== 1'b0 || s1_tready !== 1'b1) begin
               n_fail++;
               $display("FAIL hold_release H+4 got busy=%b rdy=%b exp 0 1",
                        busy, s1_tready);
            end
         end
      end
      @(negedge aclk);
      s1_tvalid = 1'b0;
   endtask

   task automatic test_back_pressure();
      do_reset();
      cfg_data = 0;
      m_tready = 1'b0;
      @(negedge aclk);
      s0_tdata  = DC;
      s0_tvalid = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge aclk);
         s0_tdata  = DA;
         s1_tdata  = DB;
         s1_tvalid = 1'b1;
         #1;
         n_tests++;
         if (m_tvalid !== 1'b1 || m_tdata !== DC || m_tid !== 1'b0 ||
             {s1_tready, s0_tready} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_stall c%0d got v=%b id=%b d=%h rdy=%b exp v=1 id=0 d=%h rdy=00",
                     c, m_tvalid, m_tid, m_tdata, {s1_tready, s0_tready}, DC);
         end
      end
      @(negedge aclk);
      m_tready = 1'b1;
      #1;
      n_tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== DC) begin
         n_fail++;
         $display("FAIL bp_release got v=%b d=%h exp v=1 d=%h", m_tvalid, m_tdata, DC);
      end
      @(negedge aclk);
      #1;
      n_tests++;
      if (m_tvalid !== 1'b0 || {s1_tready, s0_tready} !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_after got v=%b rdy=%b exp v=0 rdy=10",
                  m_tvalid, {s1_tready, s0_tready});
      end
      @(negedge aclk);
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
   endtask

   task automatic test_reset_midflight();
      // Reset during SEND.
      do_reset();
      cfg_data = 0;
      m_tready = 1'b0;
      @(negedge aclk);
      s0_tdata  = DA;
      s0_tvalid = 1'b1;
      @(negedge aclk);
      s1_tdata  = DB;
      s1_tvalid = 1'b1;
      areset    = 1'b1;
      #1;
      n_tests++;
      if ({s1_tready, s0_tready} !== 2'b00 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_send_pre got rdy=%b busy=%b exp rdy=00 busy=1",
                  {s1_tready, s0_tready}, busy);
      end
      @(negedge aclk);
      areset = 1'b0;
      #1;
      n_tests++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || m_tdata !== '0 ||
          {s1_tready, s0_tready} !== 2'b01) begin
         n_fail++;
         $display("FAIL rst_send_post got v=%b busy=%b d=%h rdy=%b exp v=0 busy=0 d=0 rdy=01",
                  m_tvalid, busy, m_tdata, {s1_tready, s0_tready});
      end
      // Reset during HOLD with a long gap.
      do_reset();
      cfg_data = 100;
      m_tready = 1'b1;
      @(negedge aclk);
      s1_tdata  = DB;
      s1_tvalid = 1'b1;
      @(negedge aclk);
      s1_tvalid = 1'b0;
      @(negedge aclk);
      #1;
      n_tests++;
      if (busy !== 1'b1 || m_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_hold_pre got busy=%b v=%b exp 1 0", busy, m_tvalid);
      end
      @(negedge aclk);
      areset    = 1'b1;
      s0_tvalid = 1'b1;
      s1_tvalid = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0 || {s1_tready, s0_tready} !== 2'b01) begin
         n_fail++;
         $display("FAIL rst_hold_post got busy=%b v=%b rdy=%b exp 0 0 01",
                  busy, m_tvalid, {s1_tready, s0_tready});
      end
      @(negedge aclk);
      s0_tvalid = 1'b0;
      s1_tvalid = 1'b0;
   endtask

   task automatic test_cfg_sample();
      int busy_hold;
      int grant_at;
      do_reset();
      cfg_data = 50;
      m_tready = 1'b1;
      @(negedge aclk);
      s0_tdata  = DA;
      s0_tvalid = 1'b1;
      @(negedge aclk);
      s0_tvalid = 1'b0;
      busy_hold = 0;
      grant_at  = -1;
      for (int c = 2; c < 120 && grant_at < 0; c++) begin
         @(negedge aclk);
         if (c == 2) cfg_data = 2;
         s0_tvalid = 1'b1;
         #1;
         if (s0_tready === 1'b1) grant_at = c;
         else if (busy === 1'b1) busy_hold++;
      end
      n_tests++;
      if (grant_at != 52) begin
         n_fail++;
         $display("FAIL cfg_regrant got cycle=%0d exp cycle=52", grant_at);
      end
      n_tests++;
      if (busy_hold != 50) begin
         n_fail++;
         $display("FAIL cfg_hold_len got=%0d exp=50", busy_hold);
      end
      @(negedge aclk);
      s0_tvalid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_hold_gap();
      test_back_pressure();
      test_reset_midflight();
      test_cfg_sample();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
